// File: rtl/bus_fifo_pkg.sv
// Shared constants and width helpers for the bus FIFO and its tri-state driver.
package bus_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_drv_bh.sv
// Generic tri-state bus driver: Q follows D while EN is high, floats otherwise.
module bus_drv_bh #(
    parameter int WIDTH = 8
) (
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output tri   [WIDTH-1:0] Q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign Q[gi] = EN ? D[gi] : 1'bz;
    end

endmodule

// File: rtl/bus_fifo_bh.sv
// Circular-buffer FIFO whose head entry is driven onto a tri-state bus.
// Optional sticky ERR output is enabled by defining BUS_FIFO_ERR_FLAG_EN.
module bus_fifo_bh
    import bus_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                           CLK,
    input  logic                           CLR,
    input  logic                           LOAD,
    input  logic                           POP,
    input  logic                           ENABLE,
    input  logic [WIDTH-1:0]               X,
    output tri   [WIDTH-1:0]               Y,
    output logic                           FULL,
    output logic                           EMPTY,
    output logic [count_width(DEPTH)-1:0]  COUNT
`ifdef BUS_FIFO_ERR_FLAG_EN
    ,
    output logic                           ERR
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign FULL  = (count_reg == CW'(DEPTH));
    assign EMPTY = (count_reg == '0);
    assign COUNT = count_reg;

    // A full FIFO still accepts a push when the same edge pops the head.
    assign do_pop  = POP && !EMPTY;
    assign do_push = LOAD && (!FULL || POP);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage is never cleared; only the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (!CLR && do_push)
            mem[wr_ptr_reg] <= X;
    end

`ifdef BUS_FIFO_ERR_FLAG_EN
    logic err_reg;

    always_ff @(posedge CLK) begin
        if (CLR)
            err_reg <= 1'b0;
        else if ((LOAD && FULL && !POP) || (POP && EMPTY))
            err_reg <= 1'b1;
    end

    assign ERR = err_reg;
`endif

    bus_drv_bh #(
        .WIDTH (WIDTH)
    ) u_drv (
        .EN (ENABLE && !EMPTY),
        .D  (mem[rd_ptr_reg]),
        .Q  (Y)
    );

endmodule

// File: doc/bus_fifo_bh.md
BUS_FIFO_BH -- requirements
Module: bus_fifo_bh

Interface
REQ-001 Parameter WIDTH, default 8: data bits per entry and bus width.
REQ-002 Parameter DEPTH, default 4: number of entries; legal values are powers of two, 2 or greater.
REQ-003 CLK  input  1: the single clock; all state updates on the rising edge.
REQ-004 CLR  input  1: reset, synchronous and active-high.
REQ-005 LOAD  input  1: push request; X is written at the tail.
REQ-006 POP  input  1: pop request; the head entry is discarded.
REQ-007 ENABLE  input  1: bus drive enable for Y.
REQ-008 X  input  WIDTH: write data from the bus.
REQ-009 Y  output  WIDTH: tri-state bus output carrying the head entry.
REQ-010 FULL  output  1: high when the entry count equals DEPTH.
REQ-011 EMPTY  output  1: high when the entry count is 0.
REQ-012 COUNT  output  clog2(DEPTH)+1: number of occupied entries.

Function
REQ-013 Storage SHALL be a circular buffer with wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-014 Push (LOAD=1, FULL=0) SHALL store X at wr_ptr, advance wr_ptr and increment COUNT on the same edge.
REQ-015 Pop (POP=1, EMPTY=0) SHALL advance rd_ptr and decrement COUNT on the same edge.
REQ-016 LOAD=1 while FULL=1 and POP=0 SHALL drop X and leave all state unchanged.
REQ-017 POP=1 while EMPTY=1 SHALL be ignored; all state unchanged.
REQ-018 LOAD=1 and POP=1 together while neither FULL nor EMPTY SHALL push and pop; COUNT unchanged.
REQ-019 LOAD=1 and POP=1 together while FULL SHALL pop the head and push X; COUNT stays DEPTH.
REQ-020 LOAD=1 and POP=1 together while EMPTY SHALL push only; COUNT becomes 1.
REQ-021 Y SHALL equal mem[rd_ptr] combinationally when ENABLE=1 and EMPTY=0, and SHALL be all-Z otherwise.
REQ-022 Read latency: data pushed at edge N SHALL appear on Y after edge N when the FIFO was empty.
REQ-023 FULL, EMPTY and COUNT SHALL be registered-state decodes with no combinational path from LOAD or POP.

Reset
REQ-024 CLR=1 at a rising edge SHALL set wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1 and FULL=0, and SHALL override LOAD and POP.
REQ-025 Memory contents SHALL NOT be cleared by reset; Y is Z after reset regardless of ENABLE, because EMPTY=1.

Configuration
REQ-026 With BUS_FIFO_ERR_FLAG_EN defined: add output ERR (1 bit), a sticky flag set on a dropped push (REQ-016) or an ignored pop (REQ-017), cleared only by CLR.
REQ-027 Without BUS_FIFO_ERR_FLAG_EN: no ERR port and no flag logic; all other behaviour is identical.

Structure
REQ-028 Package bus_fifo_pkg SHALL hold the default WIDTH and DEPTH constants and a function giving the pointer and count widths from DEPTH.
REQ-029 The tri-state output SHALL be a sub-module bus_drv_bh (parameter WIDTH; ports EN, D, Q), reusable by other bus drivers.

Verification
REQ-030 CLR; push 0x11, 0x22, 0x33, 0x44 with ENABLE=1 -> FULL=1, COUNT=4, Y=0x11.
REQ-031 From that full state, push 0x55 with POP=0 -> Y=0x11, COUNT=4; ERR=1 if BUS_FIFO_ERR_FLAG_EN is defined.
REQ-032 From that full state, pop four times -> Y sequence 0x22, 0x33, 0x44, then Z; EMPTY=1.
REQ-033 With the FIFO empty, assert LOAD and POP together with X=0xA5 -> COUNT=1, Y=0xA5; then ENABLE=0 -> Y all-Z.
REQ-034 Wrap-around: 10 cycles of simultaneous push and pop with data 0..9 after one preload of 0xFF -> Y follows 0xFF, 0, 1, ..., 8; COUNT stays 1.
REQ-035 Assert CLR mid-stream with COUNT=3 and LOAD=1 -> next cycle COUNT=0, EMPTY=1, Y=Z, ERR=0.
